// File: rtl/sram_burst_controller.sv
// sram_burst_controller: bursts DATA_W-bit words to/from a 16-bit asynchronous SRAM, then stalls and pulses ready
module sram_burst_controller #(
    parameter int          DATA_W      = 32,
    parameter int          SRAM_DQ_W   = 16,
    parameter int          SRAM_ADDR_W = 18,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          BURST_LEN   = 1,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wr_en,
    input  logic                          i_rd_en,
    input  logic [31:0]                   i_address,
    input  logic [BURST_LEN*DATA_W-1:0]   i_write_data,
    output logic [BURST_LEN*DATA_W-1:0]   o_read_data,
    output logic                          o_ready,
    inout  wire  [SRAM_DQ_W-1:0]          io_sram_dq,
    output logic [SRAM_ADDR_W-1:0]        o_sram_addr,
    output logic                          o_sram_we_n,
    output logic                          o_sram_oe_n,
    output logic                          o_sram_ub_n,
    output logic                          o_sram_lb_n,
    output logic                          o_sram_ce_n
);
    localparam int K  = DATA_W / SRAM_DQ_W;
    localparam int N  = BURST_LEN * K;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    localparam int SH = $clog2(DATA_W / 8);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_CAPT, STALL, DONE} state_t;

    state_t                       r_state, w_next, w_tail;
    logic [SRAM_ADDR_W-1:0]       r_base, w_base;
    logic [IW-1:0]                r_idx;
    logic [3:0]                   r_wait;
    logic [N-1:0][SRAM_DQ_W-1:0]  r_wdata, r_rdata;
    logic                         w_last, w_drive;

    // r_base holds W*K so each access address is just r_base + flat half index
    assign w_base      = SRAM_ADDR_W'(((i_address - BASE_ADDR) >> SH) * 32'(K));
    assign w_last      = r_idx == IW'(N - 1);
    assign w_tail      = (WAIT_CYCLES == 0) ? DONE : STALL;
    assign o_sram_addr = r_base + SRAM_ADDR_W'(r_idx);
    assign io_sram_dq  = w_drive ? r_wdata[r_idx] : 'z;
    assign o_read_data = r_rdata;
    assign o_sram_ub_n = 1'b0;
    assign o_sram_lb_n = 1'b0;
    assign o_sram_ce_n = 1'b0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_wr_en ? WRITE : i_rd_en ? RD_ADDR : IDLE;
            WRITE:   w_next = w_last ? w_tail : WRITE;
            RD_ADDR: w_next = RD_CAPT;
            RD_CAPT: w_next = w_last ? w_tail : RD_ADDR;
            STALL:   w_next = (r_wait == 4'd0) ? DONE : STALL;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready     = (r_state == DONE) || (r_state == IDLE && !(i_wr_en || i_rd_en));
        o_sram_we_n = r_state != WRITE;
        o_sram_oe_n = r_state == WRITE;
        w_drive     = r_state == WRITE;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base  <= '0;
            r_idx   <= '0;
            r_wait  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == IDLE) begin
                r_base  <= w_base;
                r_wdata <= i_write_data;
            end
            r_idx  <= (r_state == WRITE || r_state == RD_CAPT) ? r_idx + IW'(1) :
                      (r_state == RD_ADDR) ? r_idx : '0;
            r_wait <= (r_state == STALL) ? r_wait - 4'd1 : WAIT_INIT;
            if (r_state == RD_CAPT)
                r_rdata[r_idx] <= io_sram_dq;
        end
    end
endmodule

// File: tb/tb_sram_burst_controller.sv
// tb_sram_burst_controller: scoreboard bench with two controller configurations and behavioural SRAM models
module tb_sram_burst_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         wr [2];
    logic         rd [2];
    logic [31:0]  addr [2];
    logic [127:0] wd [2];
    wire  [31:0]  rdata0;
    wire  [127:0] rdata1;
    wire  [15:0]  dq0, dq1;
    logic         rdy [2], we_n [2], oe_n [2], ub [2], lb [2], ce [2];
    logic [17:0]  sa [2];
    logic [15:0]  dqv [2];
    logic [127:0] rdv [2];

    sram_burst_controller u0 (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr[0]), .i_rd_en(rd[0]), .i_address(addr[0]),
        .i_write_data(wd[0][31:0]), .o_read_data(rdata0), .o_ready(rdy[0]), .io_sram_dq(dq0),
        .o_sram_addr(sa[0]), .o_sram_we_n(we_n[0]), .o_sram_oe_n(oe_n[0]),
        .o_sram_ub_n(ub[0]), .o_sram_lb_n(lb[0]), .o_sram_ce_n(ce[0])
    );

    sram_burst_controller #(.BURST_LEN(4), .WAIT_CYCLES(0)) u1 (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr[1]), .i_rd_en(rd[1]), .i_address(addr[1]),
        .i_write_data(wd[1]), .o_read_data(rdata1), .o_ready(rdy[1]), .io_sram_dq(dq1),
        .o_sram_addr(sa[1]), .o_sram_we_n(we_n[1]), .o_sram_oe_n(oe_n[1]),
        .o_sram_ub_n(ub[1]), .o_sram_lb_n(lb[1]), .o_sram_ce_n(ce[1])
    );

    // SRAM models: drive DQ while OE_N low and WE_N high, store on clock edges with WE_N low
    logic [15:0] mem [2][262144];
    logic        pre_en = 1'b0;
    int          pre_d;
    logic [17:0] pre_a;
    logic [15:0] pre_v;

    assign dq0 = (!oe_n[0] && we_n[0]) ? mem[0][sa[0]] : 16'bz;
    assign dq1 = (!oe_n[1] && we_n[1]) ? mem[1][sa[1]] : 16'bz;
    assign dqv[0] = dq0;
    assign dqv[1] = dq1;
    assign rdv[0] = {96'b0, rdata0};
    assign rdv[1] = rdata1;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            if (!we_n[d]) mem[d][sa[d]] <= dqv[d];
        if (pre_en) mem[pre_d][pre_a] <= pre_v;
    end

    typedef struct packed {logic d; logic [17:0] a; logic [15:0] v;} acc_t;
    typedef struct packed {logic d; logic rd; logic [7:0] lat; logic [127:0] data;} done_t;
    acc_t  wq [$];
    done_t dn [$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic exp_w(input logic d, input logic [17:0] a, input logic [15:0] v);
        wq.push_back(acc_t'{d: d, a: a, v: v});
    endtask

    task automatic exp_done(input logic d, input logic r, input logic [7:0] lat, input logic [127:0] data);
        dn.push_back(done_t'{d: d, rd: r, lat: lat, data: data});
    endtask

    // monitor: pops the scoreboard on every SRAM write access and every completion pulse
    int   cyc [2];
    logic busy [2] = '{1'b0, 1'b0};
    acc_t  ea;
    done_t ed;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("oe_vs_we%0d", d), oe_n[d], !we_n[d]);
            if (!we_n[d]) begin
                if (wq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write dut%0d: got WE_N low at %h, expected no access", d, sa[d]);
                end else begin
                    ea = wq.pop_front();
                    chk("wr_dut", 128'(d), 128'(ea.d));
                    chk("wr_addr", sa[d], ea.a);
                    chk("wr_data", dqv[d], ea.v);
                end
            end
            if (rst) begin
                busy[d] = 1'b0;
            end else if (!busy[d]) begin
                if (wr[d] || rd[d]) begin
                    busy[d] = 1'b1;
                    cyc[d] = 0;
                    chk("ready_low_on_req", rdy[d], 1'b0);
                end
            end else begin
                cyc[d]++;
                if (rdy[d]) begin
                    busy[d] = 1'b0;
                    if (dn.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_done dut%0d: got ready at cycle %0d, expected none", d, cyc[d]);
                    end else begin
                        ed = dn.pop_front();
                        chk("done_dut", 128'(d), 128'(ed.d));
                        chk("latency", 128'(cyc[d]), 128'(ed.lat));
                        if (ed.rd) chk("read_data", rdv[d], ed.data);
                    end
                end
            end
        end
    end

    task automatic preload(input int d, input logic [17:0] a, input logic [15:0] v);
        @(posedge clk);
        #1 pre_en = 1'b1; pre_d = d; pre_a = a; pre_v = v;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic req(input int d, input logic w, input logic r, input logic [31:0] a,
                       input logic [127:0] v, input logic tog);
        int n = 0;
        @(posedge clk);
        #1 wr[d] = w; rd[d] = r; addr[d] = a; wd[d] = v;
        do begin
            @(negedge clk);
            n++;
            if (!rdy[d] && tog && n > 1) #1 rd[d] = ~rd[d];
        end while (!rdy[d] && n < 200);
        if (!rdy[d]) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout dut%0d: ready still low after %0d cycles, expected a pulse", d, n);
        end
        @(posedge clk);
        #1 wr[d] = 1'b0; rd[d] = 1'b0;
        @(posedge clk);
    endtask

    logic [127:0] burst;

    initial begin
        for (int d = 0; d < 2; d++) begin
            wr[d] = 1'b0; rd[d] = 1'b0; addr[d] = '0; wd[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", rdy[d], 1'b1);
            chk("rst_we_n", we_n[d], 1'b1);
            chk("rst_oe_n", oe_n[d], 1'b0);
            chk("rst_ties", {ub[d], lb[d], ce[d]}, 3'b000);
            chk("rst_read_data", rdv[d], '0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // single word write at the base address
        exp_w(0, 18'd0, 16'hBEEF);
        exp_w(0, 18'd1, 16'hDEAD);
        exp_done(0, 0, 8'd5, '0);
        req(0, 1, 0, 32'd1024, 128'hDEADBEEF, 0);
        chk("mem0_0", mem[0][0], 16'hBEEF);
        chk("mem0_1", mem[0][1], 16'hDEAD);

        // read of preloaded halves
        preload(0, 18'd2, 16'h1234);
        preload(0, 18'd3, 16'hABCD);
        exp_done(0, 1, 8'd7, 128'hABCD1234);
        req(0, 0, 1, 32'd1028, '0, 0);

        // simultaneous requests: write wins, rd_en toggling mid-operation is ignored
        exp_w(0, 18'd4, 16'hF00D);
        exp_w(0, 18'd5, 16'hCAFE);
        exp_done(0, 0, 8'd5, '0);
        req(0, 1, 1, 32'd1032, 128'hCAFEF00D, 1);
        chk("read_hold", rdata0, 32'hABCD1234);
        exp_done(0, 1, 8'd7, 128'hCAFEF00D);
        req(0, 0, 1, 32'd1034, '0, 0);

        // address below the base wraps to the top of SRAM
        exp_w(0, 18'h3FFFE, 16'hA5A5);
        exp_w(0, 18'h3FFFF, 16'h5A5A);
        exp_done(0, 0, 8'd5, '0);
        req(0, 1, 0, 32'd1020, 128'h5A5AA5A5, 0);
        exp_done(0, 1, 8'd7, 128'h5A5AA5A5);
        req(0, 0, 1, 32'd1020, '0, 0);

        // four-word burst without stall, written then read back
        burst = 128'h77778888_55556666_33334444_11112222;
        for (int i = 0; i < 4; i++) begin
            exp_w(1, 18'(8 + 2 * i), burst[i*32 +: 16]);
            exp_w(1, 18'(9 + 2 * i), burst[i*32+16 +: 16]);
        end
        exp_done(1, 0, 8'd9, '0);
        req(1, 1, 0, 32'd1040, burst, 0);
        exp_done(1, 1, 8'd17, burst);
        req(1, 0, 1, 32'd1040, '0, 0);
        chk("mem1_15", mem[1][15], 16'h7777);

        // reset in the second write cycle aborts at once
        exp_w(0, 18'd6, 16'h2222);
        @(posedge clk);
        #1 wr[0] = 1'b1; addr[0] = 32'd1036; wd[0] = 128'h11112222;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_we_n", we_n[0], 1'b1);
        chk("abort_oe_n", oe_n[0], 1'b0);
        chk("abort_ready_req", rdy[0], 1'b0);
        chk("abort_read_data", rdata0, 32'h0);
        wr[0] = 1'b0;
        #1;
        chk("abort_ready_idle", rdy[0], 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("abort_half_written", mem[0][6], 16'h2222);
        chk("abort_ready_after", rdy[0], 1'b1);

        chk("write_queue_empty", 128'(wq.size()), '0);
        chk("done_queue_empty", 128'(dn.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
